// File: rtl/acc_rmw_ctrl.sv
// Read-modify-write accumulator in front of a 4x80b partial-sum RAM; drains on last beat.
// Define ACC_SAT_EN for signed saturating accumulation (wrapping add otherwise).
module acc_rmw_ctrl #(
    parameter int DATA_W = 80,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_last,
    output logic [ADDR_W-1:0] ram_rdaddress,
    output logic [ADDR_W-1:0] ram_wraddress,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CW    = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_ACC,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] p_q, p_d;
    logic [ADDR_W-1:0] p_prev_q, p_prev_d;
    logic              rvalid_q, rvalid_d;
    logic              issued_q, issued_d;
    logic [ADDR_W-1:0] wraddr_q, wraddr_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_last_q, out_last_d;

    logic [ADDR_W-1:0] rd_addr;
    logic              wren;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] sum;
    logic              accept;
    logic              capture;
    logic              advance;

    function automatic logic [DATA_W-1:0] acc_add(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] s;
        s = a + b;
`ifdef ACC_SAT_EN
        if (a[DATA_W-1] == b[DATA_W-1] && s[DATA_W-1] != a[DATA_W-1]) begin
            s = a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                            : {1'b0, {(DATA_W-1){1'b1}}};
        end
`endif
        return s;
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        pend_d      = 1'b0;
        data_d      = data_q;
        p_d         = p_q;
        p_prev_d    = p_prev_q;
        rvalid_d    = rvalid_q;
        issued_d    = issued_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;
        rd_addr     = '0;
        wren        = 1'b0;
        wdata       = '0;
        capture     = 1'b0;
        advance     = 1'b0;
        accept      = 1'b0;
        sum         = acc_add(ram_q, data_q);

        unique case (state_q)
            S_CLEAR: begin
                rd_addr = cnt_q[ADDR_W-1:0];
                wren    = (cnt_q != '0);
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(DEPTH)) begin
                    state_d    = S_ACC;
                    in_ready_d = 1'b1;
                    cnt_d      = '0;
                end
            end
            S_ACC: begin
                accept  = in_valid && in_ready_q;
                rd_addr = in_addr;
                if (accept) begin
                    pend_d = 1'b1;
                    data_d = in_data;
                    if (in_last) begin
                        in_ready_d = 1'b0;
                        state_d    = S_DRAIN;
                        p_d        = '0;
                        issued_d   = 1'b0;
                        rvalid_d   = 1'b0;
                    end
                end
            end
            S_DRAIN: begin
                capture = rvalid_q && (!out_valid_q || out_ready);
                advance = !issued_q && (!rvalid_q || capture);
                // On a stall the held slot is re-read so ram_q stays valid.
                rd_addr = (rvalid_q && !capture) ? p_prev_q : p_q;
                if (advance) begin
                    p_prev_d = p_q;
                    p_d      = p_q + 1'b1;
                    rvalid_d = 1'b1;
                    issued_d = (p_q == LAST_SLOT);
                end else if (capture) begin
                    rvalid_d = 1'b0;
                end
                if (capture && p_prev_q == LAST_SLOT) begin
                    state_d    = S_ACC;
                    in_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase

        if (pend_q) begin
            wren  = 1'b1;
            wdata = sum;
        end
        if (capture) begin
            wren        = 1'b1;
            wdata       = '0;
            out_valid_d = 1'b1;
            out_data_d  = ram_q;
            out_addr_d  = p_prev_q;
            out_last_d  = (p_prev_q == LAST_SLOT);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        wraddr_d = rd_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_CLEAR;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            pend_q      <= 1'b0;
            data_q      <= '0;
            p_q         <= '0;
            p_prev_q    <= '0;
            rvalid_q    <= 1'b0;
            issued_q    <= 1'b0;
            wraddr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            pend_q      <= pend_d;
            data_q      <= data_d;
            p_q         <= p_d;
            p_prev_q    <= p_prev_d;
            rvalid_q    <= rvalid_d;
            issued_q    <= issued_d;
            wraddr_q    <= wraddr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign busy          = (state_q != S_ACC);
    assign ram_rdaddress = rd_addr;
    assign ram_wraddress = wraddr_q;
    assign ram_wren      = wren;
    assign ram_data      = wdata;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_addr      = out_addr_q;
    assign out_last      = out_last_q;

endmodule

// File: tb/tb_acc_rmw_ctrl.sv
// Scoreboard bench for acc_rmw_ctrl with a bypassing 1-cycle RAM model.
// Honours ACC_SAT_EN in its reference adder.
module tb_acc_rmw_ctrl;

    localparam int DW    = 80;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam logic signed [DW:0] SMAX = {2'b00, {(DW-1){1'b1}}};
    localparam logic signed [DW:0] SMIN = {2'b11, {(DW-1){1'b0}}};

    typedef struct {
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic          l;
    } sb_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [AW-1:0] in_addr = '0;
    logic          in_last = 1'b0;
    logic [AW-1:0] ram_rdaddress;
    logic [AW-1:0] ram_wraddress;
    logic          ram_wren;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_q = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          busy;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wa = '0;
    logic [DW-1:0] acc [DEPTH];
    sb_t           sb [$];
    int            checks = 0;
    int            fails = 0;
    int            stalls = 0;
    logic          mon_en = 1'b1;

    always #5 clk = ~clk;

    acc_rmw_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_addr       (in_addr),
        .in_last       (in_last),
        .ram_rdaddress (ram_rdaddress),
        .ram_wraddress (ram_wraddress),
        .ram_wren      (ram_wren),
        .ram_data      (ram_data),
        .ram_q         (ram_q),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_addr      (out_addr),
        .out_last      (out_last),
        .busy          (busy)
    );

    // RAM is not reset: during rst it is filled with junk to prove re-zeroing.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= {16'hDEAD, 32'(i + 7), 32'hBEEF_0001};
            end
        end else if (ram_wren) begin
            mem[wa] <= ram_data;
        end
        ram_q <= (!rst && ram_wren && wa == ram_rdaddress) ? ram_data
                                                            : mem[ram_rdaddress];
        wa <= ram_rdaddress;
    end

    task automatic check_eq(input string tag, input logic [DW-1:0] act,
                            input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] madd(input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
        logic signed [DW:0] s;
        s = $signed({a[DW-1], a}) + $signed({b[DW-1], b});
`ifdef ACC_SAT_EN
        if (s > SMAX) s = SMAX;
        if (s < SMIN) s = SMIN;
`endif
        return s[DW-1:0];
    endfunction

    always @(negedge clk) begin : mon
        sb_t e;
        if (mon_en && !rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("sb_unexpected", DW'(out_addr), DW'(5));
            end else begin
                e = sb.pop_front();
                check_eq($sformatf("out_data[%0d]", e.a), out_data, e.d);
                check_eq("out_addr", DW'(out_addr), DW'(e.a));
                check_eq("out_last", DW'(out_last), DW'(e.l));
            end
        end
    end

    task automatic zero_model();
        for (int i = 0; i < DEPTH; i++) acc[i] = '0;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic l);
        int w;
        w = 0;
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            w++;
            @(negedge clk);
        end
        if (w >= 50) check_eq("send_timeout", DW'(in_ready), DW'(1));
        stalls += w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        acc[a] = madd(acc[a], d);
        if (l) begin
            for (int i = 0; i < DEPTH; i++) begin
                sb.push_back('{d: acc[i], a: AW'(i), l: (i == DEPTH - 1)});
                acc[i] = '0;
            end
        end
    endtask

    task automatic clear_check();
        for (int c = 0; c <= DEPTH; c++) begin
            @(negedge clk);
            check_eq("clr_in_ready", DW'(in_ready), DW'(0));
            check_eq("clr_busy", DW'(busy), DW'(1));
            check_eq("clr_out_valid", DW'(out_valid), DW'(0));
            check_eq("clr_wren", DW'(ram_wren), DW'(c != 0));
            if (c != 0) begin
                check_eq("clr_data", ram_data, '0);
                check_eq("clr_wraddr", DW'(ram_wraddress), DW'(c - 1));
            end
        end
        @(negedge clk);
        check_eq("acc_in_ready", DW'(in_ready), DW'(1));
        check_eq("acc_busy", DW'(busy), DW'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check_eq("drain_done", DW'(sb.size()), DW'(0));
        @(negedge clk);
        check_eq("post_drain_ready", DW'(in_ready), DW'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] held;
        int            w;
        zero_model();

        @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", DW'(out_valid), DW'(0));
        check_eq("rst_out_data", out_data, '0);
        check_eq("rst_in_ready", DW'(in_ready), DW'(0));
        check_eq("rst_wren", DW'(ram_wren), DW'(0));
        check_eq("rst_busy", DW'(busy), DW'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_check();

        send(2'd0, 80'd5, 1'b0);
        send(2'd1, 80'd7, 1'b0);
        send(2'd0, 80'd3, 1'b1);
        wait_drain();

        stalls = 0;
        for (int i = 0; i < 10; i++) send(2'd2, 80'd1, i == 9);
        check_eq("b2b_stalls", DW'(stalls), DW'(0));
        wait_drain();

        // Downstream stall with an ignored beat offered during drain.
        out_ready = 1'b0;
        send(2'd3, 80'd11, 1'b0);
        send(2'd1, 80'd22, 1'b1);
        in_valid = 1'b1;
        in_addr  = 2'd2;
        in_data  = 80'd999;
        w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        held = out_data;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("stall_valid", DW'(out_valid), DW'(1));
            check_eq("stall_data", out_data, 80'd0);
            check_eq("stall_hold", out_data, held);
            check_eq("stall_addr", DW'(out_addr), DW'(0));
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        send(2'd3, {1'b0, {(DW-1){1'b1}}}, 1'b0);
        send(2'd0, {{(DW-3){1'b1}}, 3'b011}, 1'b0);
        send(2'd0, 80'd2, 1'b0);
        send(2'd3, 80'd1, 1'b1);
        wait_drain();

        for (int i = 0; i < 8; i++) begin
            send(AW'($urandom_range(0, DEPTH - 1)),
                 {16'($urandom), $urandom, $urandom}, i == 7);
        end
        wait_drain();

        // Reset while slot 1 is on the output.
        mon_en = 1'b0;
        send(2'd1, 80'd9, 1'b0);
        send(2'd3, 80'd4, 1'b1);
        w = 0;
        while (!(out_valid && out_addr == 2'd1) && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_eq("mid_drain_seen", DW'(out_addr), DW'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        zero_model();
        mon_en = 1'b1;
        clear_check();
        send(2'd2, 80'd2, 1'b1);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
